// File: rtl/madnes_oam_pkg.sv
// Shared OAM arbiter types and sizes: object layout, queued CPU write entry, CPU read FSM states.
package madnes_oam_pkg;

    localparam int unsigned OAM_ADDR_SIZE = 8;
    localparam int unsigned FIFO_DEPTH    = 4;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned SY_W          = 10;
    localparam int unsigned LEVEL_W       = $clog2(FIFO_DEPTH) + 1;

    // One 32-bit OAM word as seen by the line-preparation block
    typedef struct packed {
        logic [7:0] spriteref;
        logic [9:0] x;
        logic [9:0] y;
        logic       prio;
        logic       xflip;
        logic       yflip;
        logic       en;
    } oam_obj_t;

    typedef struct packed {
        logic [OAM_ADDR_SIZE-1:0] addr;
        logic [DATA_W-1:0]        data;
    } oam_wr_t;

    typedef enum logic {
        S_IDLE,
        S_RD_WAIT
    } rd_state_t;

endpackage

// File: rtl/oam_wr_fifo.sv
// Synchronous CPU write FIFO; pointers carry an extra wrap bit to tell full from empty.
module oam_wr_fifo
    import madnes_oam_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  oam_wr_t                    wr_entry,
    input  logic                       pop,
    output oam_wr_t                    rd_entry,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    oam_wr_t        mem [DEPTH];
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset; occupancy is governed by the pointers alone
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wr_entry;
    end

    assign rd_entry = mem[rd_ptr[PTR_W-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign level    = wr_ptr - rd_ptr;

endmodule

// File: rtl/oam_port_arbiter.sv
// Shares the single-port OAM RAM: scanner always wins, CPU writes queue and retire in idle cycles.
// Define OAM_CPU_READ_EN to build the CPU read path; otherwise the read ports are tied off.
module oam_port_arbiter
    import madnes_oam_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [SY_W-1:0]           sy,
    input  logic                      scan_busy,
    input  logic [OAM_ADDR_SIZE-1:0]  scan_addr,
    output logic [DATA_W-1:0]         scan_data,
    input  logic                      cpu_wr_valid,
    output logic                      cpu_wr_ready,
    input  logic [OAM_ADDR_SIZE-1:0]  cpu_wr_addr,
    input  logic [DATA_W-1:0]         cpu_wr_data,
    input  logic                      cpu_rd_valid,
    output logic                      cpu_rd_ready,
    input  logic [OAM_ADDR_SIZE-1:0]  cpu_rd_addr,
    output logic [DATA_W-1:0]         cpu_rd_data,
    output logic                      cpu_rd_done,
    output logic [OAM_ADDR_SIZE-1:0]  ram_addr,
    output logic                      ram_we,
    output logic [DATA_W-1:0]         ram_wdata,
    input  logic [DATA_W-1:0]         ram_rdata,
    output logic [LEVEL_W-1:0]        fifo_level
);
    logic [SY_W-1:0] last_sy;
    logic            scan_req;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            rd_grant;
    oam_wr_t         wr_entry;
    oam_wr_t         head;

    // A new scanline starts scanning before the scanner raises busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_sy <= 10'h3FF;
        else       last_sy <= sy;
    end

    assign scan_req     = scan_busy || (sy != last_sy);
    assign cpu_wr_ready = !fifo_full;
    assign push         = cpu_wr_valid && !fifo_full;
    assign pop          = !scan_req && !fifo_empty;
    assign wr_entry     = '{addr: cpu_wr_addr, data: cpu_wr_data};
    assign scan_data    = ram_rdata;

    oam_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .wr_entry (wr_entry),
        .pop      (pop),
        .rd_entry (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // Port priority: scanner, then queued writes, then a granted read
    always_comb begin
        ram_addr  = scan_addr;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (!scan_req) begin
            if (pop) begin
                ram_addr  = head.addr;
                ram_we    = 1'b1;
                ram_wdata = head.data;
            end else if (rd_grant) begin
                ram_addr = cpu_rd_addr;
            end
        end
    end

`ifdef OAM_CPU_READ_EN
    rd_state_t state;

    // Reads wait for an empty FIFO and no same-cycle push, so they see every earlier write
    assign cpu_rd_ready = !reset && (state == S_IDLE) && !scan_req && fifo_empty && !push;
    assign rd_grant     = cpu_rd_valid && cpu_rd_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cpu_rd_data <= '0;
            cpu_rd_done <= 1'b0;
        end else begin
            cpu_rd_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rd_grant) state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // RAM data belongs to last cycle's read address even if the scanner took the port now
                    cpu_rd_data <= ram_rdata;
                    cpu_rd_done <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`else
    logic unused_rd_valid;

    assign unused_rd_valid = cpu_rd_valid;
    assign rd_grant        = 1'b0;
    assign cpu_rd_ready    = 1'b0;
    assign cpu_rd_done     = 1'b0;
    assign cpu_rd_data     = '0;
`endif

endmodule
